// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the MIPS-16 instruction-memory loader.
package mips_imem_loader_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 256;

  typedef logic [15:0] instr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VERIFY,
    RUN
  } loader_state_e;

endpackage

// File: rtl/mips_loader_cksum.sv
// Wrapping accumulator with synchronous clear and add-enable; clear has priority.
module mips_loader_cksum #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] add_data,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_reg;

  assign sum = sum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg <= '0;
    end else if (clr) begin
      sum_reg <= '0;
    end else if (add_en) begin
      sum_reg <= sum_reg + add_data;
    end
  end

endmodule

// File: rtl/mips_imem_loader.sv
// Streams a program into the MIPS-16 instruction memory and holds the core in reset until done.
// Optional readback verification pass is enabled with `define MIPS_LOADER_READBACK_EN.
module mips_imem_loader
  import mips_imem_loader_pkg::*;
#(
  parameter int DATA_W = $bits(instr_t),
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef MIPS_LOADER_READBACK_EN
  output logic              imem_re,
  input  logic [DATA_W-1:0] imem_rdata,
`endif
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  loader_state_e     state_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   idx_reg;
  logic              imem_we_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic [DATA_W-1:0] imem_wdata_reg;
  logic              core_rst_reg;
  logic              run_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic start_legal;
  logic start_ok;
  logic accept;
  logic last_accept;

  assign start_legal = (word_count != '0) && (word_count <= DEPTH_C);
  assign start_ok    = start && start_legal && ((state_reg == IDLE) || (state_reg == RUN));
  assign s_ready     = (state_reg == LOAD);
  assign accept      = s_valid && s_ready;
  assign last_accept = accept && (idx_reg == count_reg - 1'b1);

  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign core_rst   = core_rst_reg;
  assign run        = run_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;

  // Summing on accept makes the new checksum visible together with the write it covers.
  mips_loader_cksum #(.W(DATA_W)) u_wr_cksum (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .add_en   (accept),
    .add_data (s_data),
    .sum      (checksum)
  );

`ifdef MIPS_LOADER_READBACK_EN
  logic            imem_re_reg;
  logic            rd_pend_reg;
  logic [ADDR_W:0] vcnt_reg;
  logic [ADDR_W:0] vcnt_inc;
  logic [DATA_W-1:0] rb_sum;
  logic            rb_match;

  assign imem_re  = imem_re_reg;
  assign vcnt_inc = vcnt_reg + 1'b1;
  // The final word is still on imem_rdata in the decision cycle, so fold it in here.
  assign rb_match = (rb_sum + imem_rdata) == checksum;

  mips_loader_cksum #(.W(DATA_W)) u_rb_cksum (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_reg == FLUSH),
    .add_en   (rd_pend_reg),
    .add_data (imem_rdata),
    .sum      (rb_sum)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      idx_reg        <= '0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      core_rst_reg   <= 1'b1;
      run_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef MIPS_LOADER_READBACK_EN
      imem_re_reg    <= 1'b0;
      rd_pend_reg    <= 1'b0;
      vcnt_reg       <= '0;
`endif
    end else begin
      imem_we_reg <= 1'b0;
      done_reg    <= 1'b0;
`ifdef MIPS_LOADER_READBACK_EN
      imem_re_reg <= 1'b0;
      rd_pend_reg <= imem_re_reg;
`endif
      case (state_reg)
        IDLE, RUN: begin
          if (start) begin
            core_rst_reg <= 1'b1;
            run_reg      <= 1'b0;
            if (start_legal) begin
              count_reg     <= word_count;
              idx_reg       <= '0;
              imem_addr_reg <= '0;
              err_reg       <= 1'b0;
              busy_reg      <= 1'b1;
              state_reg     <= LOAD;
            end else begin
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            imem_we_reg    <= 1'b1;
            imem_addr_reg  <= idx_reg[ADDR_W-1:0];
            imem_wdata_reg <= s_data;
            idx_reg        <= idx_reg + 1'b1;
            if (last_accept) begin
              state_reg <= FLUSH;
            end
          end
        end
        FLUSH: begin
`ifdef MIPS_LOADER_READBACK_EN
          imem_re_reg   <= 1'b1;
          imem_addr_reg <= '0;
          vcnt_reg      <= '0;
          state_reg     <= VERIFY;
`else
          busy_reg     <= 1'b0;
          core_rst_reg <= 1'b0;
          run_reg      <= 1'b1;
          done_reg     <= 1'b1;
          state_reg    <= RUN;
`endif
        end
`ifdef MIPS_LOADER_READBACK_EN
        VERIFY: begin
          vcnt_reg <= vcnt_inc;
          if (vcnt_inc < count_reg) begin
            imem_re_reg   <= 1'b1;
            imem_addr_reg <= vcnt_inc[ADDR_W-1:0];
          end
          if (vcnt_reg == count_reg) begin
            busy_reg <= 1'b0;
            if (rb_match) begin
              core_rst_reg <= 1'b0;
              run_reg      <= 1'b1;
              done_reg     <= 1'b1;
              state_reg    <= RUN;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
